// File: rtl/instr_decode.sv
// Instruction decode stage: issues data ops to the execution unit and resolves
// control flow (jump, conditional jump, yield, halt) toward the fetch stage.
module instr_decode #(
  parameter int          N_THREADS = 16,
  parameter int          INSTR_LEN = 16,
  parameter int          IADDR_LEN = 10,
  parameter int          N_STAGES  = 4,
  parameter logic [1:0]  TS_IDLE   = 2'b00,
  localparam int         TW        = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [N_STAGES-1:0]  stage_allow,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic [TW-1:0]        thread_num,
  input  logic                 cond_flag,
  input  logic                 eu_ready,
  output logic                 eu_valid,
  output logic [2:0]           eu_op,
  output logic [11:0]          eu_operand,
  output logic                 INVALIDATE,
  output logic                 INSTR_WAIT,
  output logic                 EXECUTED,
  output logic                 JUMP,
  output logic [IADDR_LEN-1:0] jump_addr,
  output logic                 NEXT_THREAD,
  output logic                 ts_wr_en,
  output logic [TW-1:0]        ts_wr_num,
  output logic [1:0]           ts_wr,
  output logic                 err
);

  typedef enum logic [1:0] {RUN, WAIT_EU, SWITCH} state_e;

  state_e               state_q, state_d;
  logic [INSTR_LEN-1:0] hold_q, hold_d;
  logic [TW-1:0]        holdThr_q, holdThr_d;
  logic                 euValid_q, euValid_d;
  logic [2:0]           euOp_q, euOp_d;
  logic [11:0]          euOperand_q, euOperand_d;
  logic                 inval_q, inval_d;
  logic                 iwait_q, iwait_d;
  logic                 exec_q, exec_d;
  logic                 jump_q, jump_d;
  logic [IADDR_LEN-1:0] jaddr_q, jaddr_d;
  logic                 next_q, next_d;
  logic                 tsEn_q, tsEn_d;
  logic [TW-1:0]        tsNum_q, tsNum_d;
  logic [1:0]           tsWr_q, tsWr_d;
  logic                 err_q, err_d;

  logic [3:0]  opcode, holdOpc;
  logic [11:0] operand;
  logic        unused_stage;

  assign opcode       = instruction[INSTR_LEN-1 -: 4];
  assign operand      = instruction[11:0];
  assign holdOpc      = hold_q[INSTR_LEN-1 -: 4];
  assign unused_stage = ^{stage_allow[N_STAGES-1:2], stage_allow[0]};

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    holdThr_d   = holdThr_q;
    euValid_d   = 1'b0;
    euOp_d      = euOp_q;
    euOperand_d = euOperand_q;
    inval_d     = 1'b0;
    iwait_d     = 1'b0;
    exec_d      = 1'b0;
    jump_d      = 1'b0;
    jaddr_d     = jaddr_q;
    next_d      = 1'b0;
    tsEn_d      = 1'b0;
    tsNum_d     = tsNum_q;
    tsWr_d      = tsWr_q;
    err_d       = err_q;

    unique case (state_q)
      RUN: begin
        if (stage_allow[1]) begin
          unique case (opcode)
            4'd0: exec_d = 1'b1;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
              if (eu_ready) begin
                euValid_d   = 1'b1;
                euOp_d      = opcode[2:0];
                euOperand_d = operand;
                exec_d      = 1'b1;
              end else begin
                hold_d  = instruction;
                iwait_d = 1'b1;
                state_d = WAIT_EU;
              end
            end
            default: begin
              // Not-taken JMPC behaves as NOP; everything else flushes fetch
              // and finishes in SWITCH using the held word and thread.
              if (opcode == 4'd9 && !cond_flag) begin
                exec_d = 1'b1;
              end else begin
                hold_d    = instruction;
                holdThr_d = thread_num;
                inval_d   = 1'b1;
                state_d   = SWITCH;
                if (opcode >= 4'd12) err_d = 1'b1;
              end
            end
          endcase
        end
      end
      WAIT_EU: begin
        if (euValid_q && eu_ready) err_d = 1'b1;
        if (eu_ready) begin
          euValid_d   = 1'b1;
          euOp_d      = holdOpc[2:0];
          euOperand_d = hold_q[11:0];
          exec_d      = 1'b1;
          state_d     = RUN;
        end else begin
          iwait_d = 1'b1;
        end
      end
      SWITCH: begin
        next_d  = 1'b1;
        state_d = RUN;
        unique case (holdOpc)
          4'd8, 4'd9: begin
            jump_d  = 1'b1;
            jaddr_d = hold_q[IADDR_LEN-1:0];
          end
          4'd10: exec_d = 1'b1;
          default: begin
            tsEn_d  = 1'b1;
            tsNum_d = holdThr_q;
            tsWr_d  = TS_IDLE;
          end
        endcase
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= RUN;
      hold_q      <= '0;
      holdThr_q   <= '0;
      euValid_q   <= 1'b0;
      euOp_q      <= '0;
      euOperand_q <= '0;
      inval_q     <= 1'b0;
      iwait_q     <= 1'b0;
      exec_q      <= 1'b0;
      jump_q      <= 1'b0;
      jaddr_q     <= '0;
      next_q      <= 1'b0;
      tsEn_q      <= 1'b0;
      tsNum_q     <= '0;
      tsWr_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      holdThr_q   <= holdThr_d;
      euValid_q   <= euValid_d;
      euOp_q      <= euOp_d;
      euOperand_q <= euOperand_d;
      inval_q     <= inval_d;
      iwait_q     <= iwait_d;
      exec_q      <= exec_d;
      jump_q      <= jump_d;
      jaddr_q     <= jaddr_d;
      next_q      <= next_d;
      tsEn_q      <= tsEn_d;
      tsNum_q     <= tsNum_d;
      tsWr_q      <= tsWr_d;
      err_q       <= err_d;
    end
  end

  assign eu_valid    = euValid_q;
  assign eu_op       = euOp_q;
  assign eu_operand  = euOperand_q;
  assign INVALIDATE  = inval_q;
  assign INSTR_WAIT  = iwait_q;
  assign EXECUTED    = exec_q;
  assign JUMP        = jump_q;
  assign jump_addr   = jaddr_q;
  assign NEXT_THREAD = next_q;
  assign ts_wr_en    = tsEn_q;
  assign ts_wr_num   = tsNum_q;
  assign ts_wr       = tsWr_q;
  assign err         = err_q;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed test-plan steps followed by
// random instructions, each checked cycle by cycle against a behavioural model.
module tb_instr_decode;

  logic        CLK;
  logic        RESET_N;
  logic [3:0]  stage_allow;
  logic [15:0] instruction;
  logic [3:0]  thread_num;
  logic        cond_flag;
  logic        eu_ready;
  logic        eu_valid;
  logic [2:0]  eu_op;
  logic [11:0] eu_operand;
  logic        INVALIDATE;
  logic        INSTR_WAIT;
  logic        EXECUTED;
  logic        JUMP;
  logic [9:0]  jump_addr;
  logic        NEXT_THREAD;
  logic        ts_wr_en;
  logic [3:0]  ts_wr_num;
  logic [1:0]  ts_wr;
  logic        err;

  int errors = 0;
  int checks = 0;
  logic errModel = 1'b0;

  localparam int K_NOP = 0, K_DATA = 1, K_JUMP = 2, K_YIELD = 3, K_HALT = 4;

  instr_decode dut (
    .CLK(CLK), .RESET_N(RESET_N), .stage_allow(stage_allow),
    .instruction(instruction), .thread_num(thread_num), .cond_flag(cond_flag),
    .eu_ready(eu_ready), .eu_valid(eu_valid), .eu_op(eu_op),
    .eu_operand(eu_operand), .INVALIDATE(INVALIDATE), .INSTR_WAIT(INSTR_WAIT),
    .EXECUTED(EXECUTED), .JUMP(JUMP), .jump_addr(jump_addr),
    .NEXT_THREAD(NEXT_THREAD), .ts_wr_en(ts_wr_en), .ts_wr_num(ts_wr_num),
    .ts_wr(ts_wr), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Strobe vector order: {eu_valid, INVALIDATE, INSTR_WAIT, EXECUTED, JUMP, NEXT_THREAD, ts_wr_en}
  function automatic logic [6:0] obsStrobes();
    return {eu_valid, INVALIDATE, INSTR_WAIT, EXECUTED, JUMP, NEXT_THREAD, ts_wr_en};
  endfunction

  function automatic logic [6:0] expStrobes(input int kind, input int c, input int d);
    logic [6:0] s = '0;
    case (kind)
      K_NOP:   if (c == 1) s = 7'b0001000;
      K_DATA:  if (c <= d) s = 7'b0010000; else if (c == d + 1) s = 7'b1001000;
      K_JUMP:  if (c == 1) s = 7'b0100000; else if (c == 2) s = 7'b0000110;
      K_YIELD: if (c == 1) s = 7'b0100000; else if (c == 2) s = 7'b0001010;
      K_HALT:  if (c == 1) s = 7'b0100000; else if (c == 2) s = 7'b0000011;
      default: s = '0;
    endcase
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    @(negedge CLK);
    RESET_N = 1'b0;
    stage_allow = 4'b0000;
    eu_ready = 1'b0;
    errModel = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {obsStrobes(), eu_op, eu_operand, jump_addr, ts_wr_num, ts_wr, err}, '0);
  endtask

  // Present one instruction, then check every cycle until it completes plus one
  // idle cycle. d = number of edges (from accept) at which eu_ready is low.
  task automatic applyStimulus(input logic [15:0] instr, input logic [3:0] thr,
                               input logic cond, input int d, input logic drop);
    logic [3:0] op;
    int kind, dEff, len;
    op = instr[15:12];
    if (op == 4'd0 || (op == 4'd9 && !cond)) kind = K_NOP;
    else if (op <= 4'd7) kind = K_DATA;
    else if (op == 4'd8 || op == 4'd9) kind = K_JUMP;
    else if (op == 4'd10) kind = K_YIELD;
    else kind = K_HALT;
    dEff = (kind == K_DATA) ? d : 0;
    len = (kind == K_NOP) ? 1 : (kind == K_DATA) ? dEff + 1 : 2;

    @(negedge CLK);
    stage_allow = 4'b0010;
    instruction = instr;
    thread_num  = thr;
    cond_flag   = cond;
    eu_ready    = (dEff == 0);
    if (op >= 4'd12) errModel = 1'b1;

    for (int c = 1; c <= len + 1; c++) begin
      @(negedge CLK);
      checkOutput($sformatf("strobes op%0h c%0d", op, c), 32'(obsStrobes()),
                  32'(expStrobes(kind, c, dEff)));
      checkOutput($sformatf("err op%0h c%0d", op, c), 32'(err), 32'(errModel));
      if (kind == K_DATA && c == dEff + 1) begin
        checkOutput("eu_op", 32'(eu_op), 32'(op[2:0]));
        checkOutput("eu_operand", 32'(eu_operand), 32'(instr[11:0]));
      end
      if (kind == K_JUMP && c == 2)
        checkOutput("jump_addr", 32'(jump_addr), 32'(instr[9:0]));
      if (kind == K_HALT && c == 2) begin
        checkOutput("ts_wr_num", 32'(ts_wr_num), 32'(thr));
        checkOutput("ts_wr", 32'(ts_wr), 32'(2'b00));
      end
      stage_allow = (drop && c < len) ? 4'b0010 : 4'b1101;
      instruction = 16'h8123;
      thread_num  = 4'(thr + 1);
      eu_ready    = (c >= dEff);
    end
    stage_allow = 4'b0000;
  endtask

  initial begin
    RESET_N = 1'b0;
    stage_allow = '0;
    instruction = '0;
    thread_num = '0;
    cond_flag = 1'b0;
    eu_ready = 1'b0;
    #12;
    checkAllZero("reset outputs");
    doReset();
    checkAllZero("after release");

    $display("[TB] directed sequence");
    applyStimulus(16'h0000, 4'd0, 1'b0, 0, 1'b0);
    applyStimulus(16'h3ABC, 4'd0, 1'b0, 0, 1'b0);
    applyStimulus(16'h1005, 4'd1, 1'b0, 4, 1'b1);
    applyStimulus(16'h8096, 4'd3, 1'b0, 0, 1'b1);
    applyStimulus(16'h9010, 4'd3, 1'b0, 0, 1'b0);
    applyStimulus(16'h9010, 4'd3, 1'b1, 0, 1'b1);
    applyStimulus(16'hA000, 4'd4, 1'b0, 0, 1'b1);
    applyStimulus(16'hB000, 4'd5, 1'b0, 0, 1'b0);
    applyStimulus(16'hF000, 4'd2, 1'b0, 0, 1'b1);
    applyStimulus(16'h0000, 4'd2, 1'b0, 0, 1'b0);
    doReset();
    checkOutput("err cleared", 32'(err), 32'(0));

    $display("[TB] reset during WAIT_EU");
    @(negedge CLK);
    stage_allow = 4'b0010; instruction = 16'h1005; eu_ready = 1'b0;
    @(negedge CLK);
    stage_allow = 4'b0000;
    checkOutput("midwait iwait", 32'(INSTR_WAIT), 32'(1));
    @(negedge CLK);
    RESET_N = 1'b0; eu_ready = 1'b1;
    #1 checkAllZero("midwait reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("midwait after", 32'(obsStrobes()), 32'(0));
    end

    $display("[TB] reset during SWITCH");
    @(negedge CLK);
    stage_allow = 4'b0010; instruction = 16'h8096;
    @(negedge CLK);
    stage_allow = 4'b0000;
    checkOutput("midswitch inval", 32'(INVALIDATE), 32'(1));
    RESET_N = 1'b0;
    #1 checkAllZero("midswitch reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("midswitch after", 32'(obsStrobes()), 32'(0));
    end

    $display("[TB] random sequence");
    for (int n = 0; n < 40; n++) begin
      logic [15:0] rInstr;
      rInstr = 16'($urandom);
      if (n < 30 && rInstr[15:12] >= 4'd12) rInstr[15] = 1'b0;
      applyStimulus(rInstr, 4'($urandom), 1'($urandom), int'($urandom_range(0, 4)),
                    1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Downstream neighbour of the instruction-fetch stage.
- Consumes the raw instruction word registered out of instruction BRAM, together with stage_allow.
- Decodes the opcode, issues data operations to the execution unit with a ready/valid handshake, and resolves control flow (jump, conditional jump, yield, halt).
- Drives the fetch-side controls EXECUTED, JUMP/jump_addr, NEXT_THREAD, INVALIDATE and INSTR_WAIT, plus a thread-state write for halted threads.

Parameters:
N_THREADS, 16, thread count; thread-number width is MSB(N_THREADS-1)+1.
INSTR_LEN, 16, instruction width; opcode = [INSTR_LEN-1 -: 4], operand = [11:0].
IADDR_LEN, 10, instruction address width; jump target = operand[IADDR_LEN-1:0].
N_STAGES, 4, width of stage_allow.
TS_IDLE, 2'b00, thread-state value written on HALT.

Ports:
CLK  in  1  clock
RESET_N  in  1  reset, asynchronous assert, active-low
stage_allow  in  N_STAGES  bit[1] = instruction input valid this cycle
instruction  in  INSTR_LEN  instruction word from fetch
thread_num  in  MSB(N_THREADS-1)+1  thread currently executing
cond_flag  in  1  condition for JMPC, sampled with the instruction
eu_ready  in  1  execution unit accepts an op this cycle
eu_valid  out  1  op issue strobe
eu_op  out  3  opcode[2:0] of the issued data op
eu_operand  out  12  operand of the issued data op
INVALIDATE  out  1  flush fetch pipeline; asserted exactly 1 cycle before NEXT_THREAD
INSTR_WAIT  out  1  stall fetch
EXECUTED  out  1  advance effective IP
JUMP  out  1  take jump_addr; always asserted together with NEXT_THREAD
jump_addr  out  IADDR_LEN  jump target
NEXT_THREAD  out  1  switch thread
ts_wr_en  out  1  thread-state write enable
ts_wr_num  out  MSB(N_THREADS-1)+1  thread index for the state write
ts_wr  out  2  thread-state value
err  out  1  sticky error flag

Behaviour:
- Reset (RESET_N=0, asynchronous): every output is 0, jump_addr is 0, FSM state is RUN, holding register is empty.
- All outputs are registered. An instruction accepted at edge T produces its outputs during cycle T+1.
- Accept condition: stage_allow[1]=1 and state=RUN.
- Opcode map:
  - 0 NOP.
  - 1–7 DATA ops.
  - 8 JMP.
  - 9 JMPC.
  - 10 YIELD.
  - 11 HALT.
  - 12–15 illegal.
- FSM states: RUN, WAIT_EU, SWITCH.
- NOP: EXECUTED=1 for 1 cycle.
- DATA with eu_ready=1:
  - eu_valid=1 and EXECUTED=1 for 1 cycle.
  - eu_op and eu_operand come from the instruction.
- DATA with eu_ready=0:
  - Instruction goes into the holding register; state → WAIT_EU; INSTR_WAIT=1.
  - Each cycle in WAIT_EU, eu_ready is re-sampled.
  - When eu_ready=1: next cycle eu_valid=1, EXECUTED=1, INSTR_WAIT=0, state → RUN.
  - stage_allow[1] is ignored in WAIT_EU; fetch is stalled.
- JMP, and JMPC with cond_flag=1:
  - Cycle T+1: INVALIDATE=1, state → SWITCH.
  - Cycle T+2: JUMP=1, NEXT_THREAD=1, jump_addr=operand; EXECUTED=0.
  - State → RUN.
- JMPC with cond_flag=0: handled as NOP.
- YIELD: INVALIDATE at T+1; at T+2, NEXT_THREAD=1 and EXECUTED=1; JUMP=0.
- HALT:
  - INVALIDATE at T+1.
  - At T+2: NEXT_THREAD=1, EXECUTED=0, ts_wr_en=1, ts_wr=TS_IDLE, ts_wr_num = thread_num latched at accept.
- Illegal opcode: err is set (sticky until reset), then the instruction is handled as HALT.
- Instructions presented while in SWITCH are discarded; they are the invalidated prefetch.
- INVALIDATE is never asserted on two consecutive cycles.
- INSTR_WAIT and INVALIDATE are never both 1.
- Reset asserted mid-WAIT_EU or mid-SWITCH aborts the operation: no eu_valid and no NEXT_THREAD follow release.
- err is also set if eu_ready is observed 1 while eu_valid is already 1 on a held re-issue. This is an internal consistency check and never expected.

Test Plan:
- Reset release, then NOP (0x0000) with stage_allow[1]=1 → EXECUTED=1 at T+1 only; no other output strobes.
- DATA 0x3ABC, eu_ready=1 → at T+1: eu_valid=1, eu_op=3, eu_operand=0xABC, EXECUTED=1.
- DATA 0x1005, eu_ready held 0 for 3 cycles then 1:
  - INSTR_WAIT=1 for 4 cycles.
  - eu_valid and EXECUTED pulse once, in the cycle INSTR_WAIT drops.
  - A second instruction presented during the stall is not issued.
- JMP 0x8096 (jump_addr=150):
  - INVALIDATE at T+1.
  - JUMP=NEXT_THREAD=1 and jump_addr=150 at T+2.
  - An instruction presented at T+1 is dropped.
- JMPC 0x9010:
  - With cond_flag=0 → EXECUTED only.
  - With cond_flag=1 → INVALIDATE, then JUMP with jump_addr=16.
- HALT on thread 5, then opcode 0xF000 on thread 2:
  - First: ts_wr_en=1, ts_wr_num=5, ts_wr=0 together with NEXT_THREAD.
  - Second: err=1 and remains 1; same halt sequence for thread 2.
  - RESET_N pulse clears err.
